// File: rtl/debounce_scan_ctrl_if.sv
// Event handshake carrying debounced press/release events from debounce_scan_ctrl
// to the downstream control FSM (master = producer, slave = consumer).
interface debounce_scan_ctrl_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_rise;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_rise,
        output evt_ready
    );
endinterface

// File: rtl/debounce_scan_ctrl.sv
// Multi-channel switch debouncer sharing one sample tick, with a round-robin event serialiser.
// Optional macro DEBOUNCE_OVF_EN adds sticky per-channel drop flags (ovf) with a clear input (ovf_clr).
module debounce_scan_ctrl #(
    parameter int NUM_SW     = 4,
    parameter int TICK_BITS  = 20,
    parameter int STABLE_CNT = 2,
    parameter int ID_W       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SW-1:0]    sw,
    output logic [NUM_SW-1:0]    db,
    output logic [NUM_SW-1:0]    press,
    // named release_o because "release" is a reserved word
    output logic [NUM_SW-1:0]    release_o,
`ifdef DEBOUNCE_OVF_EN
    output logic [NUM_SW-1:0]    ovf,
    input  logic [NUM_SW-1:0]    ovf_clr,
`endif
    debounce_scan_ctrl_if.master evt
);

    typedef enum logic [1:0] {ZERO, WAIT_ONE, ONE, WAIT_ZERO} db_state_e;

    localparam logic [2:0] STABLE_LAST = 3'(STABLE_CNT - 1);
    localparam logic [2:0] STABLE_SAT  = 3'(STABLE_CNT);

    logic [NUM_SW-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [TICK_BITS-1:0] tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic [NUM_SW-1:0]    pend_v, pend_k;
    logic                 xfer;

    logic                 evt_valid_q, evt_valid_d;
    logic                 evt_rise_q, evt_rise_d;
    logic [ID_W-1:0]      evt_id_q, evt_id_d;
    logic [ID_W-1:0]      rr_q, rr_d;

    always_comb begin
        sync1_d    = sw;
        sync2_d    = sync1_q;
        tick_cnt_d = tick_cnt_q + TICK_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tick_cnt_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick = &tick_cnt_q;
    assign xfer = evt_valid_q && evt.evt_ready;

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_ch
        db_state_e  state_q, state_d;
        logic [2:0] cnt_q, cnt_d;
        logic       db_q, db_d, press_q, press_d, rel_q, rel_d;
        logic       pend_v_q, pend_v_d, pend_k_q, pend_k_d;
        logic       take;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= ZERO;
                cnt_q    <= '0;
                db_q     <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                pend_v_q <= 1'b0;
                pend_k_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                db_q     <= db_d;
                press_q  <= press_d;
                rel_q    <= rel_d;
                pend_v_q <= pend_v_d;
                pend_k_q <= pend_k_d;
            end
        end

        // The level test comes before the tick, so a glitch always wins over acceptance.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                ZERO: begin
                    if (sync2_q[gi]) begin
                        state_d = WAIT_ONE;
                        cnt_d   = '0;
                    end
                end
                WAIT_ONE: begin
                    if (!sync2_q[gi]) begin
                        state_d = ZERO;
                    end else if (tick) begin
                        if (cnt_q >= STABLE_LAST) begin
                            state_d = ONE;
                            cnt_d   = STABLE_SAT;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                ONE: begin
                    if (!sync2_q[gi]) begin
                        state_d = WAIT_ZERO;
                        cnt_d   = '0;
                    end
                end
                WAIT_ZERO: begin
                    if (sync2_q[gi]) begin
                        state_d = ONE;
                    end else if (tick) begin
                        if (cnt_q >= STABLE_LAST) begin
                            state_d = ZERO;
                            cnt_d   = STABLE_SAT;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end
            endcase
        end

        always_comb begin
            db_d    = (state_d == ONE) || (state_d == WAIT_ZERO);
            press_d = (state_q == WAIT_ONE) && (state_d == ONE);
            rel_d   = (state_q == WAIT_ZERO) && (state_d == ZERO);
        end

        // A slot being handed off this cycle can accept a new event without loss.
        always_comb begin
            take     = xfer && (evt_id_q == ID_W'(gi));
            pend_v_d = pend_v_q && !take;
            pend_k_d = pend_k_q;
            if ((press_q || rel_q) && (!pend_v_q || take)) begin
                pend_v_d = 1'b1;
                pend_k_d = press_q;
            end
        end

`ifdef DEBOUNCE_OVF_EN
        logic ovf_q, ovf_d;

        always_comb begin
            ovf_d = (ovf_q && !ovf_clr[gi]) || ((press_q || rel_q) && pend_v_q && !take);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_d;
            end
        end

        assign ovf[gi] = ovf_q;
`endif

        assign db[gi]        = db_q;
        assign press[gi]     = press_q;
        assign release_o[gi] = rel_q;
        assign pend_v[gi]    = pend_v_q;
        assign pend_k[gi]    = pend_k_q;
    end

    // Round-robin pick: lowest full slot at/after rr_q, else lowest full slot below it.
    logic            hi_found, lo_found, hi_rise, lo_rise;
    logic [ID_W-1:0] hi_pick, lo_pick;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_rise  = 1'b0;
        lo_rise  = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (pend_v[i]) begin
                if (ID_W'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_pick  = ID_W'(i);
                    hi_rise  = pend_k[i];
                end else begin
                    lo_found = 1'b1;
                    lo_pick  = ID_W'(i);
                    lo_rise  = pend_k[i];
                end
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_rise_d  = evt_rise_q;
        rr_d        = rr_q;
        if (evt_valid_q) begin
            if (evt.evt_ready) begin
                evt_valid_d = 1'b0;
                rr_d        = (evt_id_q == ID_W'(NUM_SW - 1)) ? '0 : evt_id_q + ID_W'(1);
            end
        end else if (hi_found || lo_found) begin
            evt_valid_d = 1'b1;
            evt_id_d    = hi_found ? hi_pick : lo_pick;
            evt_rise_d  = hi_found ? hi_rise : lo_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_rise_q  <= 1'b0;
            rr_q        <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_rise_q  <= evt_rise_d;
            rr_q        <= rr_d;
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_id    = evt_id_q;
    assign evt.evt_rise  = evt_rise_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl with a fast tick (TICK_BITS=4, STABLE_CNT=2, NUM_SW=4).
module tb_debounce_scan_ctrl;
    localparam int NUM_SW     = 4;
    localparam int TICK_BITS  = 4;
    localparam int STABLE_CNT = 2;
    localparam int ID_W       = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sw = '0;
    logic [3:0] db, press, release_o;
`ifdef DEBOUNCE_OVF_EN
    logic [3:0] ovf;
    logic [3:0] ovf_clr = '0;
`endif

    debounce_scan_ctrl_if #(.ID_W(ID_W)) evt_if ();

    debounce_scan_ctrl #(
        .NUM_SW    (NUM_SW),
        .TICK_BITS (TICK_BITS),
        .STABLE_CNT(STABLE_CNT),
        .ID_W      (ID_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db       (db),
        .press    (press),
        .release_o(release_o),
`ifdef DEBOUNCE_OVF_EN
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
`endif
        .evt      (evt_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int   press_cnt[4] = '{default: 0};
    int   rel_cnt[4]   = '{default: 0};
    int   xfer_n       = 0;
    int   xfer_id[64]  = '{default: -1};
    int   xfer_rise[64] = '{default: -1};
    int   stab_err     = 0;
    int   gap_err      = 0;
    logic prev_stall   = 1'b0;
    logic prev_xfer    = 1'b0;
    logic [1:0] prev_id = '0;
    logic prev_rise    = 1'b0;

    // Monitor: counts pulses, logs transfers, checks hold-stability and the post-transfer gap.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (press[i])     press_cnt[i]++;
                if (release_o[i]) rel_cnt[i]++;
            end
            if (prev_stall && (!evt_if.evt_valid || evt_if.evt_id != prev_id ||
                               evt_if.evt_rise != prev_rise))
                stab_err++;
            if (prev_xfer && evt_if.evt_valid)
                gap_err++;
            prev_stall = evt_if.evt_valid && !evt_if.evt_ready;
            prev_xfer  = evt_if.evt_valid && evt_if.evt_ready;
            prev_id    = evt_if.evt_id;
            prev_rise  = evt_if.evt_rise;
            if (evt_if.evt_valid && evt_if.evt_ready) begin
                if (xfer_n < 64) begin
                    xfer_id[xfer_n]   = int'(evt_if.evt_id);
                    xfer_rise[xfer_n] = int'(evt_if.evt_rise);
                end
                $display("xfer #%0d id=%0d rise=%0d t=%0t", xfer_n, evt_if.evt_id, evt_if.evt_rise, $time);
                xfer_n++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int all_press();
        int s = 0;
        for (int i = 0; i < 4; i++) s += press_cnt[i];
        return s;
    endfunction

    function automatic int all_rel();
        int s = 0;
        for (int i = 0; i < 4; i++) s += rel_cnt[i];
        return s;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int p0, r0;
        evt_if.evt_ready = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sw = 4'($urandom);
            step(1);
        end
        total++; if (db !== 4'b0) begin bad++; $display("FAIL reset_db: got %b want 0000", db); end
        total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_if.evt_valid); end
        total++; if (evt_if.evt_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", evt_if.evt_id); end
        total++; if (evt_if.evt_rise !== 1'b0) begin bad++; $display("FAIL reset_rise: got %b want 0", evt_if.evt_rise); end
        sw    = '0;
        reset = 1'b0;
        p0 = all_press();
        r0 = all_rel();
        step(20);
        total++; if (all_press() - p0 !== 0) begin bad++; $display("FAIL reset_press_quiet: got %0d want 0", all_press() - p0); end
        total++; if (all_rel() - r0 !== 0) begin bad++; $display("FAIL reset_release_quiet: got %0d want 0", all_rel() - r0); end
        total++; if (db !== 4'b0) begin bad++; $display("FAIL reset_db_after: got %b want 0000", db); end
        total++; if (evt_if.evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_after: got %b want 0", evt_if.evt_valid); end
    endtask

    task automatic test_clean_press();
        int first = -1;
        int p1, pall, x0;
        evt_if.evt_ready = 1'b1;
        p1   = press_cnt[1];
        pall = all_press();
        x0   = xfer_n;
        sw[1] = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            step(1);
            if (first < 0 && press[1]) first = n;
        end
        total++; if (first < 16 || first > 36) begin bad++; $display("FAIL clean_press_delay: got %0d want 16..36", first); end
        total++; if (press_cnt[1] - p1 !== 1) begin bad++; $display("FAIL clean_press_count: got %0d want 1", press_cnt[1] - p1); end
        total++; if (all_press() - pall !== 1) begin bad++; $display("FAIL clean_press_total: got %0d want 1", all_press() - pall); end
        total++; if (xfer_n - x0 !== 1) begin bad++; $display("FAIL clean_xfer_count: got %0d want 1", xfer_n - x0); end
        total++; if (xfer_id[x0] !== 1) begin bad++; $display("FAIL clean_xfer_id: got %0d want 1", xfer_id[x0]); end
        total++; if (xfer_rise[x0] !== 1) begin bad++; $display("FAIL clean_xfer_rise: got %0d want 1", xfer_rise[x0]); end
        total++; if (db !== 4'b0010) begin bad++; $display("FAIL clean_db: got %b want 0010", db); end
    endtask

    task automatic test_bounce();
        int p2, x0;
        p2 = press_cnt[2];
        x0 = xfer_n;
        for (int k = 0; k < 12; k++) begin
            sw[2] = ~k[0];
            step(5);
        end
        total++; if (press_cnt[2] - p2 !== 0) begin bad++; $display("FAIL bounce_no_press: got %0d want 0", press_cnt[2] - p2); end
        total++; if (xfer_n - x0 !== 0) begin bad++; $display("FAIL bounce_no_event: got %0d want 0", xfer_n - x0); end
        total++; if (db[2] !== 1'b0) begin bad++; $display("FAIL bounce_db_low: got %b want 0", db[2]); end
        sw[2] = 1'b1;
        step(45);
        total++; if (press_cnt[2] - p2 !== 1) begin bad++; $display("FAIL bounce_press_count: got %0d want 1", press_cnt[2] - p2); end
        total++; if (xfer_n - x0 !== 1) begin bad++; $display("FAIL bounce_xfer_count: got %0d want 1", xfer_n - x0); end
        total++; if (xfer_id[x0] !== 2) begin bad++; $display("FAIL bounce_xfer_id: got %0d want 2", xfer_id[x0]); end
        total++; if (xfer_rise[x0] !== 1) begin bad++; $display("FAIL bounce_xfer_rise: got %0d want 1", xfer_rise[x0]); end
        total++; if (db !== 4'b0110) begin bad++; $display("FAIL bounce_db: got %b want 0110", db); end
    endtask

    // Channels 1 and 2 fall together; pointer sits at 3, so 1 is served before 2.
    task automatic test_release();
        int r1, r2, x0;
        r1 = rel_cnt[1];
        r2 = rel_cnt[2];
        x0 = xfer_n;
        sw = 4'b0000;
        step(45);
        total++; if (rel_cnt[1] - r1 !== 1) begin bad++; $display("FAIL release_count_1: got %0d want 1", rel_cnt[1] - r1); end
        total++; if (rel_cnt[2] - r2 !== 1) begin bad++; $display("FAIL release_count_2: got %0d want 1", rel_cnt[2] - r2); end
        total++; if (xfer_n - x0 !== 2) begin bad++; $display("FAIL release_xfer_count: got %0d want 2", xfer_n - x0); end
        total++; if (xfer_id[x0] !== 1 || xfer_rise[x0] !== 0) begin bad++; $display("FAIL release_first: got id=%0d rise=%0d want id=1 rise=0", xfer_id[x0], xfer_rise[x0]); end
        total++; if (xfer_id[x0+1] !== 2 || xfer_rise[x0+1] !== 0) begin bad++; $display("FAIL release_second: got id=%0d rise=%0d want id=2 rise=0", xfer_id[x0+1], xfer_rise[x0+1]); end
        total++; if (db !== 4'b0000) begin bad++; $display("FAIL release_db: got %b want 0000", db); end
    endtask

    task automatic test_arbitration();
        int x0, s0, g0;
        sw = 4'b0000;
        evt_if.evt_ready = 1'b0;
        do_reset();
        x0 = xfer_n;
        s0 = stab_err;
        g0 = gap_err;
        sw = 4'b1011;
        step(50);
        total++; if (evt_if.evt_valid !== 1'b1) begin bad++; $display("FAIL arb_held_valid: got %b want 1", evt_if.evt_valid); end
        total++; if (evt_if.evt_id !== 2'd0) begin bad++; $display("FAIL arb_held_id: got %0d want 0", evt_if.evt_id); end
        total++; if (evt_if.evt_rise !== 1'b1) begin bad++; $display("FAIL arb_held_rise: got %b want 1", evt_if.evt_rise); end
        total++; if (xfer_n - x0 !== 0) begin bad++; $display("FAIL arb_no_xfer_stalled: got %0d want 0", xfer_n - x0); end
        evt_if.evt_ready = 1'b1;
        step(15);
        total++; if (xfer_n - x0 !== 3) begin bad++; $display("FAIL arb_xfer_count: got %0d want 3", xfer_n - x0); end
        total++; if (xfer_id[x0] !== 0 || xfer_id[x0+1] !== 1 || xfer_id[x0+2] !== 3) begin bad++; $display("FAIL arb_order: got %0d,%0d,%0d want 0,1,3", xfer_id[x0], xfer_id[x0+1], xfer_id[x0+2]); end
        total++; if (xfer_rise[x0] !== 1 || xfer_rise[x0+1] !== 1 || xfer_rise[x0+2] !== 1) begin bad++; $display("FAIL arb_rise: got %0d,%0d,%0d want 1,1,1", xfer_rise[x0], xfer_rise[x0+1], xfer_rise[x0+2]); end
        total++; if (stab_err - s0 !== 0) begin bad++; $display("FAIL arb_stable_hold: got %0d changes want 0", stab_err - s0); end
        total++; if (gap_err - g0 !== 0) begin bad++; $display("FAIL arb_valid_gap: got %0d back-to-back want 0", gap_err - g0); end
    endtask

    // Reset at a known instant zeroes the tick counter, so the fresh press lands exactly 32 cycles later.
    task automatic test_reset_mid_wait();
        int first = -1;
        int p1, x0;
        sw = 4'b0000;
        evt_if.evt_ready = 1'b1;
        do_reset();
        sw = 4'b0010;
        step(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        total++; if (db !== 4'b0000) begin bad++; $display("FAIL midrst_db: got %b want 0000", db); end
        p1 = press_cnt[1];
        x0 = xfer_n;
        for (int n = 1; n <= 45; n++) begin
            step(1);
            if (first < 0 && press[1]) first = n;
        end
        total++; if (first !== 32) begin bad++; $display("FAIL midrst_press_delay: got %0d want 32", first); end
        total++; if (press_cnt[1] - p1 !== 1) begin bad++; $display("FAIL midrst_press_count: got %0d want 1", press_cnt[1] - p1); end
        total++; if (xfer_n - x0 !== 1) begin bad++; $display("FAIL midrst_xfer_count: got %0d want 1", xfer_n - x0); end
        total++; if (xfer_id[x0] !== 1 || xfer_rise[x0] !== 1) begin bad++; $display("FAIL midrst_xfer: got id=%0d rise=%0d want id=1 rise=1", xfer_id[x0], xfer_rise[x0]); end
        total++; if (db !== 4'b0010) begin bad++; $display("FAIL midrst_db_final: got %b want 0010", db); end
    endtask

`ifdef DEBOUNCE_OVF_EN
    task automatic test_overflow();
        int x0;
        logic seen;
        sw = 4'b0000;
        evt_if.evt_ready = 1'b0;
        ovf_clr = '0;
        do_reset();
        x0 = xfer_n;
        sw[0] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 45 && !seen; n++) begin step(1); seen = press[0]; end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL ovf_first_press_timeout: got %b want 1", seen); end
        step(3);
        total++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0 || evt_if.evt_rise !== 1'b1) begin bad++; $display("FAIL ovf_first_evt: got v=%b id=%0d rise=%b want v=1 id=0 rise=1", evt_if.evt_valid, evt_if.evt_id, evt_if.evt_rise); end
        total++; if (ovf[0] !== 1'b0) begin bad++; $display("FAIL ovf_clear_before_drop: got %b want 0", ovf[0]); end
        sw[0] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 45 && !seen; n++) begin step(1); seen = release_o[0]; end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL ovf_release_timeout: got %b want 1", seen); end
        step(2);
        total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL ovf_set_on_drop: got %b want 1", ovf[0]); end
        total++; if (evt_if.evt_id !== 2'd0 || evt_if.evt_rise !== 1'b1) begin bad++; $display("FAIL ovf_evt_held: got id=%0d rise=%b want id=0 rise=1", evt_if.evt_id, evt_if.evt_rise); end
        sw[0] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 45 && !seen; n++) begin step(1); seen = press[0]; end
        step(2);
        total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf[0]); end
        ovf_clr[0] = 1'b1;
        step(1);
        ovf_clr[0] = 1'b0;
        step(1);
        total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL ovf_cleared: got %b want 0000", ovf); end
        evt_if.evt_ready = 1'b1;
        step(8);
        total++; if (xfer_n - x0 !== 1) begin bad++; $display("FAIL ovf_xfer_count: got %0d want 1", xfer_n - x0); end
        total++; if (xfer_id[x0] !== 0 || xfer_rise[x0] !== 1) begin bad++; $display("FAIL ovf_xfer: got id=%0d rise=%0d want id=0 rise=1", xfer_id[x0], xfer_rise[x0]); end
    endtask
`endif

    initial begin
        evt_if.evt_ready = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_arbitration();
        test_reset_mid_wait();
`ifdef DEBOUNCE_OVF_EN
        test_overflow();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
